// File: rtl/pipeline_stall_ctrl.sv
// PC register and IF/ID register owner: applies stall, redirect/flush and imem-not-ready holds.
// Optional perf counters are built only when PIPE_PERF_CNT_EN is defined.
module pipeline_stall_ctrl #(
    parameter int              XLEN      = 32,
    parameter logic [XLEN-1:0] RESET_PC  = 32'h0000_0000,
    parameter logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013,
    parameter int              MAX_STALL = 8,
    parameter int              CNT_W     = 32
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             stall_in,
    input  logic             redirect_in,
    input  logic [XLEN-1:0]  redirect_pc_in,
    input  logic [XLEN-1:0]  imem_instr_in,
    input  logic             imem_valid_in,
    output logic [XLEN-1:0]  pc_out,
    output logic [XLEN-1:0]  if_id_pc_out,
    output logic [XLEN-1:0]  if_id_instr_out,
    output logic             if_id_valid_out,
    output logic             id_ex_bubble_out,
    output logic             stall_err_out,
    output logic [CNT_W-1:0] stall_cnt_out,
    output logic [CNT_W-1:0] flush_cnt_out
);

    localparam int              RUN_W   = $clog2(MAX_STALL + 2);
    localparam logic [RUN_W-1:0] RUN_MAX = RUN_W'(MAX_STALL + 1);

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        STALL = 2'd1,
        FLUSH = 2'd2
    } state_t;

    state_t            state, state_nxt;
    logic [XLEN-1:0]   pc, pc_nxt;
    logic [XLEN-1:0]   ifid_pc, ifid_pc_nxt;
    logic [XLEN-1:0]   ifid_instr, ifid_instr_nxt;
    logic              ifid_valid, ifid_valid_nxt;
    logic              bubble;
    logic              stall_take;
    logic [RUN_W-1:0]  run_len, run_len_nxt;
    logic              stall_err;

    function automatic logic [RUN_W-1:0] run_sat_inc(input logic [RUN_W-1:0] v);
        return (v == RUN_MAX) ? v : v + 1'b1;
    endfunction

    // Next-state: redirect beats everything, FLUSH swallows stall, then stall, then imem-not-ready.
    always_comb begin
        state_nxt      = state;
        pc_nxt         = pc;
        ifid_pc_nxt    = ifid_pc;
        ifid_instr_nxt = ifid_instr;
        ifid_valid_nxt = ifid_valid;
        bubble         = 1'b0;
        stall_take     = 1'b0;

        if (redirect_in) begin
            pc_nxt         = redirect_pc_in & ~XLEN'(3);
            ifid_instr_nxt = NOP_INSTR;
            ifid_valid_nxt = 1'b0;
            bubble         = 1'b1;
            state_nxt      = FLUSH;
        end else if (state == FLUSH) begin
            // imem output this cycle is wrong-path; drop it but keep fetching.
            pc_nxt         = pc + XLEN'(4);
            ifid_instr_nxt = NOP_INSTR;
            ifid_valid_nxt = 1'b0;
            state_nxt      = RUN;
        end else if (stall_in) begin
            bubble     = 1'b1;
            stall_take = 1'b1;
            state_nxt  = STALL;
        end else if (!imem_valid_in) begin
            ifid_instr_nxt = NOP_INSTR;
            ifid_valid_nxt = 1'b0;
            state_nxt      = RUN;
        end else begin
            pc_nxt         = pc + XLEN'(4);
            ifid_pc_nxt    = pc;
            ifid_instr_nxt = imem_instr_in;
            ifid_valid_nxt = 1'b1;
            state_nxt      = RUN;
        end

        run_len_nxt = stall_take ? run_sat_inc(run_len) : '0;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= RUN;
            pc         <= RESET_PC;
            ifid_pc    <= '0;
            ifid_instr <= NOP_INSTR;
            ifid_valid <= 1'b0;
            run_len    <= '0;
            stall_err  <= 1'b0;
        end else begin
            state      <= state_nxt;
            pc         <= pc_nxt;
            ifid_pc    <= ifid_pc_nxt;
            ifid_instr <= ifid_instr_nxt;
            ifid_valid <= ifid_valid_nxt;
            run_len    <= run_len_nxt;
            stall_err  <= stall_err | (run_len_nxt == RUN_MAX);
        end
    end

    assign pc_out           = pc;
    assign if_id_pc_out     = ifid_pc;
    assign if_id_instr_out  = ifid_instr;
    assign if_id_valid_out  = ifid_valid;
    assign stall_err_out    = stall_err;
    // Held in reset the downstream ID/EX must see a bubble even before any clock.
    assign id_ex_bubble_out = ~reset_n | bubble;

`ifdef PIPE_PERF_CNT_EN
    logic [CNT_W-1:0] stall_cnt;
    logic [CNT_W-1:0] flush_cnt;

    function automatic logic [CNT_W-1:0] cnt_sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (stall_in && !redirect_in) begin
                stall_cnt <= cnt_sat_inc(stall_cnt);
            end
            if (redirect_in) begin
                flush_cnt <= cnt_sat_inc(flush_cnt);
            end
        end
    end

    assign stall_cnt_out = stall_cnt;
    assign flush_cnt_out = flush_cnt;
`else
    assign stall_cnt_out = '0;
    assign flush_cnt_out = '0;
`endif

endmodule

// File: tb/tb_pipeline_stall_ctrl.sv
// Scoreboard bench for pipeline_stall_ctrl: a cycle model pushes expectations as stimulus is driven,
// and they are popped and compared after the clock edge that should produce them.
module tb_pipeline_stall_ctrl;

    localparam logic [31:0] NOP = 32'h0000_0013;
    localparam int S_RUN = 0, S_STALL = 1, S_FLUSH = 2;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        stall_in, redirect_in, imem_valid_in;
    logic [31:0] redirect_pc_in, imem_instr_in;
    logic [31:0] pc_out, if_id_pc_out, if_id_instr_out;
    logic        if_id_valid_out, id_ex_bubble_out, stall_err_out;
    logic [31:0] stall_cnt_out, flush_cnt_out;

    pipeline_stall_ctrl dut (
        .clk              (clk),
        .reset_n          (reset_n),
        .stall_in         (stall_in),
        .redirect_in      (redirect_in),
        .redirect_pc_in   (redirect_pc_in),
        .imem_instr_in    (imem_instr_in),
        .imem_valid_in    (imem_valid_in),
        .pc_out           (pc_out),
        .if_id_pc_out     (if_id_pc_out),
        .if_id_instr_out  (if_id_instr_out),
        .if_id_valid_out  (if_id_valid_out),
        .id_ex_bubble_out (id_ex_bubble_out),
        .stall_err_out    (stall_err_out),
        .stall_cnt_out    (stall_cnt_out),
        .flush_cnt_out    (flush_cnt_out)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        bubble;
        logic [31:0] pc;
        logic [31:0] ifid_pc;
        logic [31:0] instr;
        logic        valid;
        logic        err;
        logic [31:0] scnt;
        logic [31:0] fcnt;
    } exp_t;

    exp_t        sb[$];
    int          n_checks = 0;
    int          n_errs   = 0;

    int          m_state;
    logic [31:0] m_pc, m_ifid_pc, m_instr, m_scnt, m_fcnt;
    logic        m_valid, m_err;
    int          m_run;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errs++;
            $display("FAIL %s: got %08h expected %08h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] instr_at(input logic [31:0] a);
        return {a[15:0], 16'h5A93} ^ 32'h1234_0000;
    endfunction

    task automatic model_reset();
        m_state = S_RUN; m_pc = 32'h0; m_ifid_pc = 32'h0; m_instr = NOP;
        m_valid = 1'b0; m_err = 1'b0; m_run = 0; m_scnt = 32'h0; m_fcnt = 32'h0;
    endtask

    task automatic model_cycle(input logic st, input logic rd, input logic [31:0] tgt,
                               input logic iv, input logic [31:0] ins, output exp_t e);
        bit in_flush;
        in_flush = (m_state == S_FLUSH);
        e.bubble = rd || (st && !in_flush);
`ifdef PIPE_PERF_CNT_EN
        if (st && !rd && m_scnt != 32'hFFFF_FFFF) m_scnt = m_scnt + 1;
        if (rd && m_fcnt != 32'hFFFF_FFFF) m_fcnt = m_fcnt + 1;
`endif
        if (st && !rd && !in_flush) m_run = (m_run < 9) ? m_run + 1 : 9;
        else m_run = 0;
        if (m_run == 9) m_err = 1'b1;
        if (rd) begin
            m_pc = {tgt[31:2], 2'b00}; m_instr = NOP; m_valid = 1'b0; m_state = S_FLUSH;
        end else if (in_flush) begin
            m_pc = m_pc + 32'd4; m_instr = NOP; m_valid = 1'b0; m_state = S_RUN;
        end else if (st) begin
            m_state = S_STALL;
        end else if (!iv) begin
            m_instr = NOP; m_valid = 1'b0; m_state = S_RUN;
        end else begin
            m_ifid_pc = m_pc; m_instr = ins; m_valid = 1'b1; m_pc = m_pc + 32'd4; m_state = S_RUN;
        end
        e.pc = m_pc; e.ifid_pc = m_ifid_pc; e.instr = m_instr; e.valid = m_valid;
        e.err = m_err; e.scnt = m_scnt; e.fcnt = m_fcnt;
    endtask

    // Called at a falling edge; returns at the next falling edge.
    task automatic step(input logic st, input logic rd, input logic [31:0] tgt, input logic iv);
        exp_t e;
        logic obs_bubble;
        stall_in = st; redirect_in = rd; redirect_pc_in = tgt; imem_valid_in = iv;
        imem_instr_in = instr_at(m_pc);
        model_cycle(st, rd, tgt, iv, imem_instr_in, e);
        sb.push_back(e);
        #1 obs_bubble = id_ex_bubble_out;
        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            check_eq("scoreboard_empty", 32'd1, 32'd0);
        end else begin
            e = sb.pop_front();
            check_eq("bubble", {31'b0, obs_bubble}, {31'b0, e.bubble});
            check_eq("pc_out", pc_out, e.pc);
            check_eq("if_id_pc", if_id_pc_out, e.ifid_pc);
            check_eq("if_id_instr", if_id_instr_out, e.instr);
            check_eq("if_id_valid", {31'b0, if_id_valid_out}, {31'b0, e.valid});
            check_eq("stall_err", {31'b0, stall_err_out}, {31'b0, e.err});
            check_eq("stall_cnt", stall_cnt_out, e.scnt);
            check_eq("flush_cnt", flush_cnt_out, e.fcnt);
        end
        @(negedge clk);
    endtask

    task automatic check_reset_values();
        check_eq("rst_pc", pc_out, 32'h0);
        check_eq("rst_if_id_pc", if_id_pc_out, 32'h0);
        check_eq("rst_if_id_instr", if_id_instr_out, NOP);
        check_eq("rst_valid", {31'b0, if_id_valid_out}, 32'd0);
        check_eq("rst_bubble", {31'b0, id_ex_bubble_out}, 32'd1);
        check_eq("rst_err", {31'b0, stall_err_out}, 32'd0);
        check_eq("rst_stall_cnt", stall_cnt_out, 32'h0);
        check_eq("rst_flush_cnt", flush_cnt_out, 32'h0);
    endtask

    // Asserts reset asynchronously mid-cycle; returns at a falling edge with reset released.
    task automatic async_reset(input int hold_cycles);
        #2 reset_n = 1'b0;
        stall_in = 1'b0; redirect_in = 1'b0; imem_valid_in = 1'b0;
        #1 check_reset_values();
        model_reset();
        sb.delete();
        repeat (hold_cycles) @(posedge clk);
        @(negedge clk);
        check_reset_values();
        reset_n = 1'b1;
    endtask

    initial begin
        reset_n = 1'b0;
        stall_in = 1'b0; redirect_in = 1'b0; imem_valid_in = 1'b0;
        redirect_pc_in = 32'h0; imem_instr_in = 32'h0;
        model_reset();
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset_values();
        reset_n = 1'b1;

        // Reset release with imem not yet ready, then fetch streams up to 0x10.
        step(1'b0, 1'b0, 32'h0, 1'b0);
        check_eq("t1_pc_after_first_edge", pc_out, 32'h0);
        repeat (4) step(1'b0, 1'b0, 32'h0, 1'b1);
        check_eq("t2_pc_before_stall", pc_out, 32'h10);

        // Load-use stall for two cycles, then resume.
        repeat (2) step(1'b1, 1'b0, 32'h0, 1'b1);
        check_eq("t2_pc_held", pc_out, 32'h10);
        step(1'b0, 1'b0, 32'h0, 1'b1);
        check_eq("t2_pc_resume", pc_out, 32'h14);

        // Redirect, flush cycle, then new-path fetch.
        step(1'b0, 1'b1, 32'h200, 1'b1);
        check_eq("t3_pc_target", pc_out, 32'h200);
        repeat (3) step(1'b0, 1'b0, 32'h0, 1'b1);

        // Redirect and stall together: redirect wins, low target bits dropped.
        step(1'b1, 1'b1, 32'h301, 1'b1);
        check_eq("t4_pc_target", pc_out, 32'h300);
        step(1'b1, 1'b0, 32'h0, 1'b1);
        step(1'b0, 1'b0, 32'h0, 1'b1);

        // Redirect during FLUSH restarts it; stall in FLUSH is ignored.
        step(1'b0, 1'b1, 32'h400, 1'b1);
        step(1'b0, 1'b1, 32'h500, 1'b1);
        step(1'b0, 1'b0, 32'h0, 1'b1);
        step(1'b0, 1'b0, 32'h0, 1'b1);

        // Watchdog: 8 stalls is tolerated, 9 sets the sticky error.
        repeat (8) step(1'b1, 1'b0, 32'h0, 1'b1);
        check_eq("t5_no_err_at_8", {31'b0, stall_err_out}, 32'd0);
        step(1'b0, 1'b0, 32'h0, 1'b1);
        repeat (9) step(1'b1, 1'b0, 32'h0, 1'b1);
        check_eq("t5_err_at_9", {31'b0, stall_err_out}, 32'd1);
        repeat (2) step(1'b0, 1'b0, 32'h0, 1'b1);

        // imem not ready for three cycles.
        repeat (3) step(1'b0, 1'b0, 32'h0, 1'b0);
        repeat (2) step(1'b0, 1'b0, 32'h0, 1'b1);

        // PC wrap across 2^32.
        step(1'b0, 1'b1, 32'hFFFF_FFFE, 1'b1);
        step(1'b0, 1'b0, 32'h0, 1'b1);
        check_eq("wrap_pc", pc_out, 32'h0);
        step(1'b0, 1'b0, 32'h0, 1'b1);

        // Reset in the middle of a stall, then in the middle of a flush.
        repeat (3) step(1'b1, 1'b0, 32'h0, 1'b1);
        async_reset(2);
        repeat (2) step(1'b0, 1'b0, 32'h0, 1'b1);
        step(1'b0, 1'b1, 32'h800, 1'b1);
        async_reset(1);
        step(1'b0, 1'b0, 32'h0, 1'b1);

        // Random traffic.
        for (int i = 0; i < 300; i++) begin
            step(($urandom_range(0, 3) == 0), ($urandom_range(0, 9) == 0),
                 $urandom, ($urandom_range(0, 5) != 0));
        end

        $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
